// File: rtl/mem_responder_pkg.sv
// Shared constants for the memory responder: I/O window addresses and the
// key debouncer state encoding.
package mem_responder_pkg;

   // Memory-mapped I/O registers (active only when the I/O window is built)
   localparam logic [7:0] IO_LED    = 8'hF0;
   localparam logic [7:0] IO_SW     = 8'hF1;
   localparam logic [7:0] IO_CNT_LO = 8'hF2;
   localparam logic [7:0] IO_CNT_HI = 8'hF3;

   // Debouncer state encoding
   localparam logic [1:0] DB_IDLE_UP   = 2'd0;
   localparam logic [1:0] DB_WAIT_DOWN = 2'd1;
   localparam logic [1:0] DB_HELD      = 2'd2;
   localparam logic [1:0] DB_WAIT_UP   = 2'd3;

endpackage

// File: rtl/mem_responder_if.sv
// Processor memory port: strobes, address and write data from the datapath,
// registered read data back from the responder.
interface mem_responder_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
);
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;

   modport master (output mem_read, output mem_write, output addr, output wdata,
                   input rdata);
   modport slave  (input mem_read, input mem_write, input addr, input wdata,
                   output rdata);
endinterface

// File: rtl/mem_responder_key_debounce.sv
// Resume-key conditioning: 2-flop synchronizer, 4-state debounce FSM with a
// stability counter, and a one-cycle snot pulse on an accepted press.
module key_debounce
   import mem_responder_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clock,
   input  logic reset,
   input  logic key_n,
   output logic snot
);
   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1, r_sync2;
   logic [1:0]       r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             w_key;

   assign w_key = r_sync2;

   // Synchronize the raw key; idles high (released)
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= key_n;
         r_sync2 <= r_sync1;
      end
   end

   // Next-state and stability-count logic
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         DB_IDLE_UP: begin
            if (!w_key) begin
               w_state_nxt = DB_WAIT_DOWN;
               w_cnt_nxt   = '0;
            end
         end
         DB_WAIT_DOWN: begin
            if (w_key)
               w_state_nxt = DB_IDLE_UP;
            else if (r_cnt == CNT_LAST)
               w_state_nxt = DB_HELD;
            else
               w_cnt_nxt = r_cnt + 1'b1;
         end
         DB_HELD: begin
            if (w_key) begin
               w_state_nxt = DB_WAIT_UP;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            if (!w_key)
               w_state_nxt = DB_HELD;
            else if (r_cnt == CNT_LAST)
               w_state_nxt = DB_IDLE_UP;
            else
               w_cnt_nxt = r_cnt + 1'b1;
         end
      endcase
   end

   // FSM state and counter registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= DB_IDLE_UP;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Pulse is high during the cycle whose edge takes WAIT_DOWN to HELD
   assign snot = (r_state == DB_WAIT_DOWN) && !w_key && (r_cnt == CNT_LAST);

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: synchronous RAM behind the processor memory port,
// optional I/O window (LEDs, switches, cycle counter) enabled by the macro
// MEM_RESPONDER_IO_EN, sticky protocol error flag and the resume-key pulse.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int DATA_W          = 8,
   parameter int ADDR_W          = 8,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic                  clock,
   input  logic                  reset,
   mem_responder_if.slave        bus,
   input  logic [7:0]            sw,
   input  logic                  key_n,
   output logic [7:0]            leds,
   output logic                  snot,
   output logic                  protocol_err
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] r_mem [0:DEPTH-1];
   logic [DATA_W-1:0] r_rdata;
   logic [DATA_W-1:0] w_rd_data;
   logic              r_perr;
   logic              w_rd;
   logic              w_ram_we;

   // A simultaneous write wins; the read is dropped
   assign w_rd = bus.mem_read & ~bus.mem_write;

`ifdef MEM_RESPONDER_IO_EN
   logic              w_win;
   logic [DATA_W-1:0] w_io_rdata;
   logic [7:0]        r_leds, r_sw1, r_sw2, r_snap;
   logic [15:0]       r_cnt;

   // Whole 0xF0-0xFF block shadows RAM; unused slots read 0, ignore writes
   assign w_win    = (bus.addr[ADDR_W-1:4] == (ADDR_W-4)'(IO_LED[7:4]));
   assign w_ram_we = bus.mem_write & ~w_win;
   assign w_rd_data = w_win ? w_io_rdata : r_mem[bus.addr];
   assign leds     = r_leds;

   // I/O read mux
   always_comb begin
      w_io_rdata = '0;
      case (bus.addr)
         ADDR_W'(IO_LED):    w_io_rdata = DATA_W'(r_leds);
         ADDR_W'(IO_SW):     w_io_rdata = DATA_W'(r_sw2);
         ADDR_W'(IO_CNT_LO): w_io_rdata = DATA_W'(r_cnt[7:0]);
         ADDR_W'(IO_CNT_HI): w_io_rdata = DATA_W'(r_snap);
         default:            w_io_rdata = '0;
      endcase
   end

   // LED register, switch synchronizer, free-running counter and snapshot
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_leds <= '0;
         r_sw1  <= '0;
         r_sw2  <= '0;
         r_cnt  <= '0;
         r_snap <= '0;
      end else begin
         r_sw1 <= sw;
         r_sw2 <= r_sw1;
         r_cnt <= r_cnt + 1'b1;
         if (bus.mem_write && bus.addr == ADDR_W'(IO_LED))
            r_leds <= bus.wdata[7:0];
         if (w_rd && bus.addr == ADDR_W'(IO_CNT_LO))
            r_snap <= r_cnt[15:8];
      end
   end
`else
   logic w_unused_sw;

   assign w_ram_we    = bus.mem_write;
   assign w_rd_data   = r_mem[bus.addr];
   assign leds        = '0;
   assign w_unused_sw = ^sw;
`endif

   // RAM write port; contents are deliberately not reset
   always_ff @(posedge clock) begin
      if (w_ram_we)
         r_mem[bus.addr] <= bus.wdata;
   end

   // Registered read data and sticky protocol error
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rdata <= '0;
         r_perr  <= 1'b0;
      end else begin
         if (w_rd)
            r_rdata <= w_rd_data;
         if (bus.mem_read && bus.mem_write)
            r_perr <= 1'b1;
      end
   end

   assign bus.rdata    = r_rdata;
   assign protocol_err = r_perr;

   key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_key_debounce (
      .clock (clock),
      .reset (reset),
      .key_n (key_n),
      .snot  (snot)
   );

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multicycle processor's memory port: serves MemRead/MemWrite strobes from the control FSM against an internal synchronous RAM plus a small memory-mapped I/O window. It also produces the one-cycle `snot` resume pulse, from a debounced pushbutton, that releases the processor from its STOP state. It sits between the processor datapath (address/data mux) and board pins (LEDs, switches, key).

## Interface
- `DATA_W`, 8: data bus width.
- `ADDR_W`, 8: address width; RAM depth is 2^ADDR_W words.
- `DEBOUNCE_CYCLES`, 50000: cycles the key must be stable before it is accepted; minimum 2.
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `mem_read`  in  1  read strobe (MemRead).
- `mem_write`  in  1  write strobe (MemWrite).
- `addr`  in  ADDR_W  word address.
- `wdata`  in  DATA_W  write data.
- `rdata`  out  DATA_W  registered read data.
- `sw`  in  8  board switches, asynchronous.
- `key_n`  in  1  resume pushbutton, active-low, asynchronous.
- `leds`  out  8  LED register.
- `snot`  out  1  resume pulse to the processor FSM.
- `protocol_err`  out  1  sticky flag for an illegal strobe combination.

## Operation
- Address decode with I/O enabled: 0xF0 LED (R/W), 0xF1 switches (R, writes ignored), 0xF2 cycle counter low (R), 0xF3 counter high snapshot (R). All other addresses map to RAM. RAM words 0xF0–0xFF are shadowed and unreachable.
- Read: at the edge where `mem_read`=1, `rdata` loads the addressed word. `rdata` holds that value until the next read.
- Write: at the edge where `mem_write`=1, the addressed location is updated. `rdata` is unchanged.
- `mem_read`=`mem_write`=1 in the same cycle: the write is performed and the read is dropped (`rdata` holds). `protocol_err` sets and stays set until reset.
- Cycle counter: 16-bit, free-running, increments every cycle, wraps 0xFFFF→0x0000. Reading 0xF2 returns the low byte and copies the high byte into a snapshot register in the same edge. 0xF3 returns the snapshot, so a read of 0xF2 followed by 0xF3 is coherent across a wrap.
- Switches: 2-flop synchronized before being readable.
- Resume key:
  - `key_n` passes through a 2-flop synchronizer, then a debouncer.
  - Debouncer states: IDLE_UP, WAIT_DOWN, HELD, WAIT_UP.
  - IDLE_UP→WAIT_DOWN when the synced key reads 0. The counter must then reach DEBOUNCE_CYCLES−1 with the key held at 0, otherwise the state returns to IDLE_UP.
  - WAIT_DOWN→HELD on completion; `snot`=1 for exactly that one transition cycle.
  - HELD→WAIT_UP when the key reads 1, with a symmetric stability count. WAIT_UP→IDLE_UP on completion; a bounce back to 0 returns to HELD.
  - A held key produces one pulse only.
- RAM contents are not reset and are undefined until written.

## Timing
- Reset values: `rdata`=0, `leds`=0, `snot`=0, `protocol_err`=0, counter=0, snapshot=0, debouncer=IDLE_UP, synchronizers=1 (key) / 0 (sw).
- Read latency: 1 edge. Data requested in cycle k is valid in cycle k+1. This meets the FSM's fetch (IR load) and load (MDR load) timing.
- Write-then-read of the same address in consecutive cycles returns the new data.
- Key press to `snot`: 2 synchronizer cycles + DEBOUNCE_CYCLES.
- Reset mid-debounce clears the count and forces `snot`=0. No pulse is emitted after reset is released unless a full new press is seen.

## Configuration
- `MEM_RESPONDER_IO_EN` defined: the I/O window, counter, snapshot, `leds` and `sw` logic are compiled in, as described above.
- Not defined: the whole address space is RAM and 0xF0–0xFF behave as ordinary RAM. `leds` is tied to 0 and `sw` is unused. The key debouncer, `snot` and `protocol_err` remain in both builds.

## Structure
- Shared package `mem_responder_pkg`: I/O address constants (`IO_LED`=0xF0, `IO_SW`=0xF1, `IO_CNT_LO`=0xF2, `IO_CNT_HI`=0xF3) and the debouncer state encoding.
- One sub-module, `key_debounce`: synchronizer, 4-state FSM and counter; outputs the `snot` pulse.
- RAM is inferred inside `mem_responder`.

## Test plan
- Write 0x5A to 0x10, read 0x10 next cycle → `rdata`=0x5A one edge after the read; `protocol_err`=0.
- Assert `mem_read` and `mem_write` together to 0x20 with wdata 0x33 → RAM[0x20]=0x33, `rdata` unchanged, `protocol_err`=1 until reset.
- I/O build: write 0xA5 to 0xF0 → `leds`=0xA5. Set `sw`=0x3C, wait 2 cycles, read 0xF1 → `rdata`=0x3C.
- Counter reaches 0x00FF: read 0xF2 then 0xF3 → 0xFF then 0x00 (snapshot coherent across the wrap).
- DEBOUNCE_CYCLES=4:
  - Bounce `key_n` low for 2 cycles → no pulse.
  - Hold it low for 10 cycles → exactly one `snot` pulse, 6 cycles after the fall.
  - Pulse `reset` mid-count → `snot` stays 0.
- Non-I/O build: write 0x77 to 0xF0, read back → 0x77; `leds`=0.
